// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD display scanner.
package bcd_disp_pkg;

  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    DRIVE
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_disp_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; nibbles above 9 show 'E'.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    if (nibble <= 4'd9) seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 8-digit common-anode BCD display driver with a one-cycle ghosting guard.
// Build option: define BCD_DISP_LZ_BLANK_EN to blank leading zeros.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] bcd_in,
  input  logic        neg_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        sign_led,
  output logic [2:0]  digit_idx
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_t        state, state_next;
  logic [PW-1:0] pre, pre_next;
  logic [2:0]    idx_next;
  logic [31:0]   value;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;
  logic          blank_digit;

  always_comb begin
    state_next = state;
    pre_next   = pre;
    idx_next   = digit_idx;
    if (!en) begin
      state_next = OFF;
      pre_next   = '0;
      idx_next   = 3'd0;
    end else begin
      unique case (state)
        OFF: begin
          state_next = BLANK;
          pre_next   = '0;
          idx_next   = 3'd0;
        end
        BLANK: begin
          state_next = DRIVE;
          pre_next   = '0;
        end
        DRIVE: begin
          if (pre == PRE_LAST) begin
            state_next = BLANK;
            pre_next   = '0;
            idx_next   = digit_idx + 3'd1;
          end else begin
            pre_next = pre + PW'(1);
          end
        end
        default: state_next = OFF;
      endcase
    end
  end

  // Outputs are registered from the next state, so an/seg always agree with the state register.
  assign nibble = value[{idx_next, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef BCD_DISP_LZ_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if (value[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end

  assign blank_digit = (idx_next > msd);
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    an_next  = 8'hFF;
    seg_next = SEG_BLANK;
    if (state_next == DRIVE) begin
      an_next  = ~(8'd1 << idx_next);
      seg_next = blank_digit ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      pre       <= '0;
      digit_idx <= 3'd0;
      an        <= 8'hFF;
      seg       <= SEG_BLANK;
    end else begin
      state     <= state_next;
      pre       <= pre_next;
      digit_idx <= idx_next;
      an        <= an_next;
      seg       <= seg_next;
    end
  end

  // load is a single-cycle strobe with no handshake; it is honoured in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= 32'd0;
      sign_led <= 1'b0;
    end else if (load) begin
      value    <= bcd_in;
      sign_led <= neg_in;
    end
  end

endmodule
